// File: rtl/uparc_ifu_pfq_if.sv
// I-Port read bus between the prefetch queue (master) and the instruction memory (slave).
//  o_IAddr  read address          o_IRdC  read command, 1-cycle pulse
//  i_IData  read data             i_IRdy  read done pulse, i_IErr  read failed pulse
interface uparc_ifu_pfq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] o_IAddr;
  logic                  o_IRdC;
  logic [DATA_WIDTH-1:0] i_IData;
  logic                  i_IRdy;
  logic                  i_IErr;

  modport master (output o_IAddr, o_IRdC, input i_IData, i_IRdy, i_IErr);
  modport slave  (input o_IAddr, o_IRdC, output i_IData, i_IRdy, i_IErr);
endinterface

// File: rtl/uparc_ifu_pfq.sv
// Instruction prefetch queue between the CPU fetch stage and the I-Port.
// Issues sequential 4-byte reads ahead of the pipeline, one outstanding at a time,
// and buffers up to DEPTH {instr, pc, error} entries. A redirect flushes the queue
// and discards any response still in flight.
//  clk, rst               clock, synchronous active-high reset
//  i_redirect(_addr)      flush and restart fetch at the given PC
//  o_valid/o_instr/o_pc   queue head; o_err_bus/o_err_align mark error entries
//  i_ready                consumer pops the head when o_valid && i_ready
//  ibus                   I-Port read bus (master side)
module uparc_ifu_pfq #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_err_bus,
  output logic                  o_err_align,
  input  logic                  i_ready,
  uparc_ifu_pfq_if.master       ibus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  err_bus;
    logic                  err_align;
  } entry_t;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DROP, ST_HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  entry_t                mem_q [DEPTH];

  logic   issue_c;
  logic   push_c;
  logic   pop_c;
  logic   flush_c;
  logic   has_space_c;
  entry_t push_entry_c;
  entry_t head_c;

  // Next-state, fetch PC and queue control.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    issue_c      = 1'b0;
    push_c       = 1'b0;
    flush_c      = 1'b0;
    push_entry_c = '0;
    has_space_c  = (count_q < CW'(DEPTH));
    pop_c        = (count_q != '0) && i_ready;

    unique case (state_q)
      ST_RUN: begin
        if (has_space_c) begin
          if (fetch_pc_q[1:0] == 2'b00) begin
            issue_c    = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            state_d    = ST_WAIT;
          end else begin
            push_c                 = 1'b1;
            push_entry_c.pc        = fetch_pc_q;
            push_entry_c.err_align = 1'b1;
            state_d                = ST_HALT;
          end
        end
      end
      ST_WAIT: begin
        if (ibus.i_IRdy) begin
          push_c             = 1'b1;
          push_entry_c.instr = ibus.i_IData;
          push_entry_c.pc    = req_pc_q;
          state_d            = ST_RUN;
        end else if (ibus.i_IErr) begin
          push_c               = 1'b1;
          push_entry_c.pc      = req_pc_q;
          push_entry_c.err_bus = 1'b1;
          state_d              = ST_HALT;
        end
      end
      ST_DROP: begin
        if (ibus.i_IRdy || ibus.i_IErr) state_d = ST_RUN;
      end
      ST_HALT: begin
      end
    endcase

    // Redirect wins over everything; a response arriving with it retires the read.
    if (i_redirect) begin
      flush_c    = 1'b1;
      push_c     = 1'b0;
      pop_c      = 1'b0;
      issue_c    = 1'b0;
      req_pc_d   = req_pc_q;
      fetch_pc_d = i_redirect_addr;
      if ((state_q == ST_WAIT || state_q == ST_DROP) && !(ibus.i_IRdy || ibus.i_IErr))
        state_d = ST_DROP;
      else
        state_d = ST_RUN;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_ADDR;
      req_pc_q   <= RESET_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      if (flush_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push_c) - CW'(pop_c);
      end
    end
  end

  // Entry storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_ptr_q] <= push_entry_c;
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign o_valid      = (count_q != '0);
  assign o_instr      = o_valid ? head_c.instr : '0;
  assign o_pc         = o_valid ? head_c.pc : '0;
  assign o_err_bus    = o_valid & head_c.err_bus;
  assign o_err_align  = o_valid & head_c.err_align;

  assign ibus.o_IAddr = fetch_pc_q;
  assign ibus.o_IRdC  = issue_c & ~rst;

endmodule

// File: tb/tb_uparc_ifu_pfq.sv
module tb_uparc_ifu_pfq;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_redirect;
  logic [AW-1:0] i_redirect_addr;
  logic          o_valid;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_pc;
  logic          o_err_bus;
  logic          o_err_align;
  logic          i_ready;

  uparc_ifu_pfq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ibus ();

  uparc_ifu_pfq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_err_bus       (o_err_bus),
    .o_err_align     (o_err_align),
    .i_ready         (i_ready),
    .ibus            (ibus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus configuration: error address and latency (0 = random 1..3 cycles, n = n cycles).
  logic          bus_err_en;
  logic [AW-1:0] bus_err_addr;
  int            lat_mode;

  // Bus responder state.
  bit            pend;
  logic [AW-1:0] pend_addr;
  bit            pend_err;
  int            pend_dly;

  // Reference model: expected entry stream since the last redirect/reset.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic          eb;
    logic          ea;
  } exp_t;
  exp_t          exp_q[$];
  exp_t          mon_e;
  bit            mon_err;
  logic [AW-1:0] exp_issue;
  bit            stop;
  int            pops = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model plus stream scoreboard, active throughout the run.
  initial begin
    ibus.i_IRdy  = 1'b0;
    ibus.i_IErr  = 1'b0;
    ibus.i_IData = '0;
    pend = 0; pend_addr = '0; pend_err = 0; pend_dly = 0;
    exp_issue = '0; stop = 0;
    forever begin
      @(posedge clk);
      #1;
      ibus.i_IRdy  = 1'b0;
      ibus.i_IErr  = 1'b0;
      ibus.i_IData = $urandom;
      if (pend) begin
        if (pend_dly == 0) begin
          pend = 0;
          if (pend_err) ibus.i_IErr = 1'b1;
          else begin
            ibus.i_IRdy  = 1'b1;
            ibus.i_IData = mem_word(pend_addr);
          end
        end else pend_dly--;
      end
      @(negedge clk);
      if (rst) begin
        pend = 0;
        exp_q.delete();
        exp_issue = '0;
        stop = 0;
      end else begin
        if (o_valid && i_ready && !i_redirect) begin
          pops++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_entry: got pc=%h err_bus=%0b err_align=%0b, no entry expected",
                     o_pc, o_err_bus, o_err_align);
          end else begin
            mon_e = exp_q.pop_front();
            if (o_pc !== mon_e.pc || o_err_bus !== mon_e.eb || o_err_align !== mon_e.ea ||
                o_instr !== ((mon_e.eb || mon_e.ea) ? '0 : mem_word(mon_e.pc))) begin
              errors++;
              $display("FAIL entry: got pc=%h instr=%h eb=%0b ea=%0b, expected pc=%h instr=%h eb=%0b ea=%0b",
                       o_pc, o_instr, o_err_bus, o_err_align, mon_e.pc,
                       (mon_e.eb || mon_e.ea) ? '0 : mem_word(mon_e.pc), mon_e.eb, mon_e.ea);
            end
          end
        end
        if (i_redirect) begin
          checks++;
          if (ibus.o_IRdC !== 1'b0) begin
            errors++;
            $display("FAIL issue_on_redirect: o_IRdC=%0b expected 0", ibus.o_IRdC);
          end
          exp_q.delete();
          exp_issue = i_redirect_addr;
          stop = 0;
        end else if (ibus.o_IRdC) begin
          checks++;
          if (pend || stop || exp_issue[1:0] != 2'b00 || ibus.o_IAddr !== exp_issue) begin
            errors++;
            $display("FAIL issue: addr=%h outstanding=%0b halted=%0b, expected addr=%h with no read outstanding",
                     ibus.o_IAddr, pend, stop, exp_issue);
          end
          mon_err = bus_err_en && (ibus.o_IAddr == bus_err_addr);
          mon_e.pc = ibus.o_IAddr; mon_e.eb = mon_err; mon_e.ea = 1'b0;
          exp_q.push_back(mon_e);
          if (mon_err) stop = 1;
          exp_issue = exp_issue + 32'd4;
          pend      = 1;
          pend_addr = ibus.o_IAddr;
          pend_err  = mon_err;
          pend_dly  = (lat_mode == 0) ? int'($urandom_range(0, 2)) : lat_mode - 1;
        end else if (!stop && exp_issue[1:0] != 2'b00) begin
          mon_e.pc = exp_issue; mon_e.eb = 1'b0; mon_e.ea = 1'b1;
          exp_q.push_back(mon_e);
          stop = 1;
        end
      end
    end
  end

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    i_redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; i_ready = 1'b1; i_redirect = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || ibus.o_IRdC !== 1'b0 || o_err_bus !== 1'b0 ||
        o_err_align !== 1'b0 || ibus.o_IAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset: valid=%0b IRdC=%0b eb=%0b ea=%0b IAddr=%h, expected all 0",
               o_valid, ibus.o_IRdC, o_err_bus, o_err_align, ibus.o_IAddr);
    end
  endtask

  task automatic test_seq_fetch();
    int n_iss = 0;
    int n_pop = 0;
    lat_mode = 1;
    tick();
    rst = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (ibus.o_IRdC !== 1'b1 || ibus.o_IAddr !== 32'h0) begin
          errors++;
          $display("FAIL t1_first_issue: IRdC=%0b IAddr=%h, expected 1 and 0", ibus.o_IRdC, ibus.o_IAddr);
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (o_valid !== (c == 2)) begin
          errors++;
          $display("FAIL t1_latency: cycle %0d valid=%0b expected %0b", c, o_valid, c == 2);
        end
      end
      if (ibus.o_IRdC) begin
        checks++;
        if (ibus.o_IAddr !== AW'(4 * n_iss)) begin
          errors++;
          $display("FAIL t1_addr: IAddr=%h expected %h", ibus.o_IAddr, 4 * n_iss);
        end
        n_iss++;
      end
      if (o_valid) begin
        checks++;
        if (o_pc !== AW'(4 * n_pop) || o_instr !== mem_word(AW'(4 * n_pop))) begin
          errors++;
          $display("FAIL t1_pc: pc=%h instr=%h expected pc=%h instr=%h",
                   o_pc, o_instr, 4 * n_pop, mem_word(AW'(4 * n_pop)));
        end
        n_pop++;
      end
    end
    checks++;
    if (n_iss != 7 || n_pop != 6) begin
      errors++;
      $display("FAIL t1_counts: issues=%0d pops=%0d expected 7 and 6", n_iss, n_pop);
    end
  endtask

  task automatic test_full();
    int n_iss = 0;
    i_ready = 1'b0; lat_mode = 1; bus_err_en = 1'b0;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (ibus.o_IRdC) begin
        checks++;
        if (ibus.o_IAddr !== AW'(4 * n_iss)) begin
          errors++;
          $display("FAIL t2_addr: IAddr=%h expected %h", ibus.o_IAddr, 4 * n_iss);
        end
        n_iss++;
      end
    end
    checks++;
    if (n_iss != int'(DEPTH) || ibus.o_IRdC !== 1'b0 || o_valid !== 1'b1 || o_pc !== 32'h0) begin
      errors++;
      $display("FAIL t2_full: issues=%0d IRdC=%0b valid=%0b pc=%h, expected %0d issues, IRdC=0, valid head pc=0",
               n_iss, ibus.o_IRdC, o_valid, o_pc, DEPTH);
    end
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ibus.o_IRdC !== 1'b1 || ibus.o_IAddr !== 32'h10) begin
      errors++;
      $display("FAIL t2_refill: IRdC=%0b IAddr=%h expected 1 and 00000010", ibus.o_IRdC, ibus.o_IAddr);
    end
    i_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_redirect_inflight();
    bit found = 0;
    i_ready = 1'b1; lat_mode = 3; bus_err_en = 1'b0;
    apply_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (ibus.o_IRdC && ibus.o_IAddr == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t3_wait_issue8: no read of 00000008 seen, expected one");
    end
    tick();
    i_redirect = 1'b1; i_redirect_addr = 32'h100;
    tick();
    i_redirect = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (ibus.o_IRdC) begin
        found = 1;
        checks++;
        if (ibus.o_IAddr !== 32'h100) begin
          errors++;
          $display("FAIL t3_new_addr: IAddr=%h expected 00000100", ibus.o_IAddr);
        end
      end
    end
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (o_valid) begin
        found = 1;
        checks++;
        if (o_pc !== 32'h100 || o_instr !== mem_word(32'h100)) begin
          errors++;
          $display("FAIL t3_head: pc=%h instr=%h expected pc=00000100 instr=%h", o_pc, o_instr, mem_word(32'h100));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t3_timeout: valid=0 expected an entry");
    end
  endtask

  task automatic test_bus_error();
    bit found = 0;
    int n_iss = 0;
    i_ready = 1'b1; lat_mode = 1; bus_err_en = 1'b1; bus_err_addr = 32'hC;
    apply_reset();
    for (int c = 0; c < 40 && !found; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (o_valid && o_err_bus) begin
        found = 1;
        checks++;
        if (o_pc !== 32'hC || o_instr !== '0 || o_err_align !== 1'b0) begin
          errors++;
          $display("FAIL t4_entry: pc=%h instr=%h ea=%0b expected pc=0000000c instr=0 ea=0", o_pc, o_instr, o_err_align);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t4_timeout: no bus-error entry, expected one");
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      if (ibus.o_IRdC) n_iss++;
    end
    checks++;
    if (n_iss != 0) begin
      errors++;
      $display("FAIL t4_halt: %0d reads while halted, expected 0", n_iss);
    end
    tick();
    i_redirect = 1'b1; i_redirect_addr = 32'h40; bus_err_en = 1'b0;
    tick();
    i_redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (ibus.o_IRdC !== 1'b1 || ibus.o_IAddr !== 32'h40) begin
      errors++;
      $display("FAIL t4_restart: IRdC=%0b IAddr=%h expected 1 and 00000040", ibus.o_IRdC, ibus.o_IAddr);
    end
  endtask

  task automatic test_align();
    int n_iss = 0;
    i_ready = 1'b0;
    tick();
    i_redirect = 1'b1; i_redirect_addr = 32'h102;
    tick();
    i_redirect = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (ibus.o_IRdC) n_iss++;
      if (c == 1) begin
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h102 || o_err_align !== 1'b1 || o_err_bus !== 1'b0 || o_instr !== '0) begin
          errors++;
          $display("FAIL t5_entry: valid=%0b pc=%h ea=%0b eb=%0b instr=%h expected 1/00000102/1/0/0",
                   o_valid, o_pc, o_err_align, o_err_bus, o_instr);
        end
      end
    end
    checks++;
    if (n_iss != 0) begin
      errors++;
      $display("FAIL t5_no_read: %0d reads, expected 0", n_iss);
    end
    tick();
    i_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_single: valid=%0b after pop, expected 0", o_valid);
    end
  endtask

  task automatic test_redirect_pop_resp();
    bit found = 0;
    i_ready = 1'b0; lat_mode = 3; bus_err_en = 1'b0;
    apply_reset();
    for (int c = 0; c < 60 && !found; c++) begin
      if (c != 0) tick();
      @(negedge clk);
      if (ibus.o_IRdC && ibus.o_IAddr == 32'h8) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL t6_wait_issue8: no read of 00000008 seen, expected one");
    end
    tick();
    tick();
    tick();
    i_redirect = 1'b1; i_redirect_addr = 32'h200; i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
      errors++;
      $display("FAIL t6_pre: valid=%0b pc=%h expected 1 and 0", o_valid, o_pc);
    end
    tick();
    i_redirect = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || ibus.o_IRdC !== 1'b1 || ibus.o_IAddr !== 32'h200) begin
      errors++;
      $display("FAIL t6_post: valid=%0b IRdC=%0b IAddr=%h expected 0/1/00000200", o_valid, ibus.o_IRdC, ibus.o_IAddr);
    end
    i_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int            pops_start;
    logic [AW-1:0] a;
    lat_mode = 0; bus_err_en = 1'b0; i_ready = 1'b1;
    apply_reset();
    pops_start = pops;
    for (int c = 0; c < 3000; c++) begin
      tick();
      i_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        a = AW'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8;
        if ($urandom_range(0, 7) == 0) a = a | AW'($urandom_range(1, 3));
        i_redirect      = 1'b1;
        i_redirect_addr = a;
        bus_err_en      = ($urandom_range(0, 2) == 0);
        bus_err_addr    = (a & ~32'h3) + AW'(4 * $urandom_range(0, 5));
      end else begin
        i_redirect = 1'b0;
      end
    end
    tick();
    i_redirect = 1'b0;
    checks++;
    if (pops - pops_start < 200) begin
      errors++;
      $display("FAIL random_progress: %0d entries consumed, expected at least 200", pops - pops_start);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_redirect = 1'b0; i_redirect_addr = '0; i_ready = 1'b0;
    bus_err_en = 1'b0; bus_err_addr = '0; lat_mode = 1;
    test_reset();
    test_seq_fetch();
    test_full();
    test_redirect_inflight();
    test_bus_error();
    test_align();
    test_redirect_pop_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
